// File: rtl/full_adder_4bit_pkg.sv
// full_adder_4bit_pkg: shared width, nibble type and result record for the 4-bit adder
package full_adder_4bit_pkg;

    localparam int ADDER_WIDTH = 4;

    typedef logic [ADDER_WIDTH-1:0] nibble_t;

    typedef struct {
        nibble_t sum;
        logic    c_out;
    } add_result_t;

endpackage

// File: rtl/full_adder_4bit_1bit.sv
// full_adder_1bit: single full-adder cell, one stage of the ripple chain
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/full_adder_4bit.sv
// full_adder_4bit: registered 4-bit ripple-carry adder; FULL_ADDER_4BIT_OVF_EN adds a registered signed-overflow flag
module full_adder_4bit
    import full_adder_4bit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef FULL_ADDER_4BIT_OVF_EN
    ,
    output logic             ovf
`endif
);

    if (WIDTH != ADDER_WIDTH) begin : g_width_check
        $error("full_adder_4bit supports only WIDTH == 4");
    end

    logic [ADDER_WIDTH:0] c;
    nibble_t              s;
    add_result_t          res;

    assign c[0] = c_in;

    for (genvar i = 0; i < ADDER_WIDTH; i++) begin : g_cell
        full_adder_1bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .c_in (c[i]),
            .sum  (s[i]),
            .c_out(c[i+1])
        );
    end

    // gather the ripple outputs into one result record
    always_comb begin
        res.sum   = s;
        res.c_out = c[ADDER_WIDTH];
    end

    // capture a result on valid beats, hold it otherwise; out_valid pulses for one cycle per beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= res.sum;
                c_out <= res.c_out;
            end
        end
    end

`ifdef FULL_ADDER_4BIT_OVF_EN
    // signed overflow: carry into the sign bit differs from carry out of it
    always_ff @(posedge clk) begin
        if (!rst_n) ovf <= 1'b0;
        else if (in_valid) ovf <= c[ADDER_WIDTH-1] ^ c[ADDER_WIDTH];
    end
`endif

endmodule

// File: tb/tb_full_adder_4bit.sv
// tb_full_adder_4bit: directed self-checking bench for full_adder_4bit (ovf checks follow FULL_ADDER_4BIT_OVF_EN)
module tb_full_adder_4bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic       c_in = 1'b0;
    logic       out_valid;
    logic [3:0] sum;
    logic       c_out;
`ifdef FULL_ADDER_4BIT_OVF_EN
    logic       ovf;
`endif

    int errors = 0;
    int checks = 0;

    full_adder_4bit #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .out_valid(out_valid),
        .sum      (sum),
        .c_out    (c_out)
`ifdef FULL_ADDER_4BIT_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y, input logic ci);
        in_valid = v;
        a        = x;
        b        = y;
        c_in     = ci;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b1, 4'h9, 4'h6, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({out_valid, c_out, sum} !== 6'b0) begin
                errors++;
                $display("FAIL reset[%0d]: got valid=%b c_out=%b sum=%h, want 0 0 0", k, out_valid, c_out, sum);
            end
`ifdef FULL_ADDER_4BIT_OVF_EN
            checks++;
            if (ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset_ovf[%0d]: got %b want 0", k, ovf);
            end
`endif
        end
        rst_n = 1'b1;
    endtask

    task automatic test_carry_chain;
        drive(1'b1, 4'b1001, 4'b0110, 1'b1);
        step();
        checks++;
        if ({out_valid, c_out, sum} !== {1'b1, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL carry_all: got valid=%b c_out=%b sum=%b, want 1 1 0000", out_valid, c_out, sum);
        end
        drive(1'b1, 4'b1001, 4'b0110, 1'b0);
        step();
        checks++;
        if ({out_valid, c_out, sum} !== {1'b1, 1'b0, 4'b1111}) begin
            errors++;
            $display("FAIL carry_none: got valid=%b c_out=%b sum=%b, want 1 0 1111", out_valid, c_out, sum);
        end
    endtask

    task automatic test_extremes;
        drive(1'b1, 4'h0, 4'h0, 1'b0);
        step();
        checks++;
        if ({out_valid, c_out, sum} !== {1'b1, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL zero: got valid=%b c_out=%b sum=%h, want 1 0 0", out_valid, c_out, sum);
        end
        drive(1'b1, 4'hF, 4'hF, 1'b1);
        step();
        checks++;
        if ({out_valid, c_out, sum} !== {1'b1, 1'b1, 4'hF}) begin
            errors++;
            $display("FAIL max: got valid=%b c_out=%b sum=%h, want 1 1 f", out_valid, c_out, sum);
        end
        drive(1'b1, 4'h8, 4'h8, 1'b0);
        step();
        checks++;
        if ({out_valid, c_out, sum} !== {1'b1, 1'b1, 4'h0}) begin
            errors++;
            $display("FAIL eight: got valid=%b c_out=%b sum=%h, want 1 1 0", out_valid, c_out, sum);
        end
`ifdef FULL_ADDER_4BIT_OVF_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL eight_ovf: got %b want 1", ovf);
        end
`endif
    endtask

    task automatic test_hold;
        drive(1'b1, 4'h3, 4'h4, 1'b0);
        step();
        checks++;
        if ({out_valid, c_out, sum} !== {1'b1, 1'b0, 4'h7}) begin
            errors++;
            $display("FAIL hold_beat: got valid=%b c_out=%b sum=%h, want 1 0 7", out_valid, c_out, sum);
        end
        drive(1'b0, 4'hE, 4'hD, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({out_valid, c_out, sum} !== {1'b0, 1'b0, 4'h7}) begin
                errors++;
                $display("FAIL hold[%0d]: got valid=%b c_out=%b sum=%h, want 0 0 7", k, out_valid, c_out, sum);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] xs [3] = '{4'h1, 4'h2, 4'h7};
        logic [3:0] ys [3] = '{4'h1, 4'h2, 4'h1};
        logic [3:0] ws [3] = '{4'h2, 4'h4, 4'h8};
        logic       os [3] = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, xs[k], ys[k], 1'b0);
            step();
            checks++;
            if ({out_valid, c_out, sum} !== {1'b1, 1'b0, ws[k]}) begin
                errors++;
                $display("FAIL b2b[%0d]: got valid=%b c_out=%b sum=%h, want 1 0 %h", k, out_valid, c_out, sum, ws[k]);
            end
`ifdef FULL_ADDER_4BIT_OVF_EN
            checks++;
            if (ovf !== os[k]) begin
                errors++;
                $display("FAIL b2b_ovf[%0d]: got %b want %b", k, ovf, os[k]);
            end
`else
            if (os[k] === 1'bx) $display("unreachable");
`endif
        end
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        step();
    endtask

    task automatic test_exhaustive;
        logic [4:0] want;
        for (int i = 0; i < 512; i++) begin
            drive(1'b1, i[3:0], i[7:4], i[8]);
            want = {1'b0, i[3:0]} + {1'b0, i[7:4]} + {4'b0, i[8]};
            step();
            checks++;
            if ({out_valid, c_out, sum} !== {1'b1, want}) begin
                errors++;
                $display("FAIL exh a=%h b=%h ci=%b: got valid=%b {c_out,sum}=%h, want 1 %h", i[3:0], i[7:4], i[8], out_valid, {c_out, sum}, want);
            end
`ifdef FULL_ADDER_4BIT_OVF_EN
            checks++;
            if (ovf !== ((i[3] == i[7]) && (want[3] != i[3]))) begin
                errors++;
                $display("FAIL exh_ovf a=%h b=%h ci=%b: got %b", i[3:0], i[7:4], i[8], ovf);
            end
`endif
        end
    endtask

    task automatic test_reset_midstream;
        logic [4:0] want;
        logic [3:0] x;
        logic [3:0] y;
        for (int k = 0; k < 20; k++) begin
            x = 4'(k * 5 + 3);
            y = 4'(k * 3 + 9);
            rst_n = (k != 10);
            drive(1'b1, x, y, k[0]);
            want = (k == 10) ? 5'd0 : {1'b0, x} + {1'b0, y} + {4'b0, k[0]};
            step();
            checks++;
            if ({out_valid, c_out, sum} !== {(k != 10), want}) begin
                errors++;
                $display("FAIL midrst[%0d]: got valid=%b {c_out,sum}=%h, want %b %h", k, out_valid, {c_out, sum}, (k != 10), want);
            end
        end
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_carry_chain();
        test_extremes();
        test_hold();
        test_back_to_back();
        test_exhaustive();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
